// File: rtl/pipe_scroller_pkg.sv
// Shared constants, column type and pipe helpers for the Flappy Bird obstacle field.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pipe_scroller_pkg;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 8;

  // One display column, bit r = row r (row 0 = top), 1 = red pixel lit.
  typedef logic [NUM_ROWS-1:0] col_t;
  // Whole field, index c = column c (col 0 = leftmost).
  typedef col_t [NUM_COLS-1:0] field_t;

  // Top row of the gap derived from the low LFSR bits. Raw values past the last
  // legal top row wrap back into range by subtracting (max_top+1).
  function automatic logic [2:0] gap_top_of(input logic [7:0] l, input int gap);
    int raw;
    int max_top;
    raw     = int'(l[2:0]);
    max_top = NUM_ROWS - gap;
    if (raw > max_top) raw = raw - (max_top + 1);
    return 3'(raw);
  endfunction

  // Solid column with `gap` open rows starting at row g.
  function automatic col_t pipe_col(input logic [2:0] g, input int gap);
    col_t c;
    for (int r = 0; r < NUM_ROWS; r++) begin
      c[r] = !((r >= int'(g)) && (r < int'(g) + gap));
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Display-side bundle of the pipe scroller: freeze in, red field and pulses out.
// Latency: n/a (wires only).
// Backpressure: none; freeze is the only upstream control and halts the field.
// Ports: freeze, red[c][r], bird_col_red, scroll_tick, pipe_passed.
interface pipe_scroller_if;
  import pipe_scroller_pkg::*;

  logic   freeze;
  field_t red;
  col_t   bird_col_red;
  logic   scroll_tick;
  logic   pipe_passed;

  modport master (
    input  freeze,
    output red,
    output bird_col_red,
    output scroll_tick,
    output pipe_passed
  );

  modport slave (
    output freeze,
    input  red,
    input  bird_col_red,
    input  scroll_tick,
    input  pipe_passed
  );

endinterface

// File: rtl/pipe_scroller_lfsr.sv
// 8-bit Fibonacci LFSR (taps 7,5,4,3) supplying pipe gap positions.
// Latency: new value visible the cycle after advance.
// Backpressure: holds whenever advance is low; a zero seed is replaced by 8'h01.
// Ports: clock, reset (sync, active-high), advance, lfsr[7:0].
module pipe_lfsr #(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] lfsr
);

  // An all-zero state would lock the register, so never load it.
  localparam logic [7:0] INIT = (SEED == 8'h00) ? 8'h01 : SEED;

  logic fb;
  assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= INIT;
    end else if (advance) begin
      lfsr <= {lfsr[6:0], fb};
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Pipe obstacle generator: emits gapped pipe columns at the right edge and scrolls the field left.
// Latency: field, scroll_tick and pipe_passed update the cycle after the divider reaches its threshold.
// Backpressure: freeze holds divider, field, spacing, LFSR and level; no pulses while frozen.
// Ports: clock, reset (sync, active-high), bus (pipe_scroller_if.master).
// Optional: PIPE_SPEEDUP_EN adds a level counter that halves the scroll period every 4 passed pipes.
module pipe_scroller
  import pipe_scroller_pkg::*;
#(
  parameter int         SCROLL_DIV   = 1792,
  parameter int         GAP          = 3,
  parameter int         PIPE_SPACING = 4,
  parameter int         BIRD_COL     = 1,
  parameter logic [7:0] SEED         = 8'h01
) (
  input logic              clock,
  input logic              reset,
  pipe_scroller_if.master  bus
);

  localparam int DW = $clog2(SCROLL_DIV + 1);
  localparam int SW = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;

  logic [DW-1:0] div_q;
  logic [DW-1:0] thresh;
  logic [SW-1:0] spacing_q;
  field_t        red_q;
  logic          scroll_tick_q;
  logic          pipe_passed_q;
  logic [7:0]    lfsr;
  logic          tick;
  logic          emit;
  logic          passing;

`ifdef PIPE_SPEEDUP_EN
  logic [1:0]    level_q;
  logic [1:0]    pass_cnt_q;
  logic [DW-1:0] thresh_raw;

  // Period shrinks with level but never below 2 cycles.
  assign thresh_raw = DW'(SCROLL_DIV) >> level_q;
  assign thresh     = (thresh_raw < DW'(2)) ? DW'(2) : thresh_raw;

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q    <= 2'd0;
      pass_cnt_q <= 2'd0;
    end else if (passing) begin
      pass_cnt_q <= pass_cnt_q + 2'd1;
      if (pass_cnt_q == 2'd3 && level_q != 2'd3) level_q <= level_q + 2'd1;
    end
  end
`else
  assign thresh = DW'(SCROLL_DIV);
`endif

  // >= rather than == so a threshold that drops below the running count ticks at once.
  assign tick    = !bus.freeze && (div_q >= thresh - DW'(1));
  assign emit    = tick && (spacing_q == '0);
  assign passing = tick && (|red_q[0]);

  // The LFSR steps on the emitting edge, so the gap uses the pre-advance value.
  pipe_lfsr #(.SEED(SEED)) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .advance (emit),
    .lfsr    (lfsr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q         <= '0;
      spacing_q     <= '0;
      red_q         <= '0;
      scroll_tick_q <= 1'b0;
      pipe_passed_q <= 1'b0;
    end else begin
      scroll_tick_q <= tick;
      pipe_passed_q <= passing;
      if (!bus.freeze) div_q <= tick ? '0 : div_q + DW'(1);
      if (tick) begin
        for (int c = 0; c < NUM_COLS - 1; c++) red_q[c] <= red_q[c+1];
        red_q[NUM_COLS-1] <= emit ? pipe_col(gap_top_of(lfsr, GAP), GAP) : '0;
        spacing_q <= (spacing_q == SW'(PIPE_SPACING - 1)) ? '0 : spacing_q + SW'(1);
      end
    end
  end

  assign bus.red          = red_q;
  assign bus.bird_col_red = red_q[BIRD_COL];
  assign bus.scroll_tick  = scroll_tick_q;
  assign bus.pipe_passed  = pipe_passed_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller with SCROLL_DIV=4: reset, pipe sequence, freeze, reset-on-tick.
// Latency: expects each tick 4 cycles apart (2 once speedup has levelled up).
// Backpressure: exercises freeze mid-period and checks the held divider on release.
module tb_pipe_scroller;
  import pipe_scroller_pkg::*;

  typedef struct {
    logic [7:0] col7;
    logic [7:0] bird;
    logic       passed;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   stray  = 0;

  always #5 clock = ~clock;

  pipe_scroller_if bus ();

  pipe_scroller #(
    .SCROLL_DIV   (4),
    .GAP          (3),
    .PIPE_SPACING (4),
    .BIRD_COL     (1),
    .SEED         (8'h01)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Step negedges until scroll_tick is seen (bounded); n = cycles taken.
  // pipe_passed on any non-tick cycle is counted as a stray pulse.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (!bus.scroll_tick && bus.pipe_passed) stray++;
    end while (!bus.scroll_tick && n < 20);
  endtask

  initial begin
    vec_t   tbl [1:25];
    int     n;
    int     exp_passes;
    int     exp_period;
    int     lead;
    int     frozen_bad;
    field_t snap;

    for (int k = 1; k <= 25; k++) tbl[k] = '{col7: 8'h00, bird: 8'h00, passed: 1'b0};
    tbl[1].col7  = 8'hF1;  tbl[5].col7  = 8'hE3;  tbl[9].col7  = 8'h8F;
    tbl[13].col7 = 8'hF8;  tbl[17].col7 = 8'hF1;  tbl[21].col7 = 8'hC7;
    tbl[25].col7 = 8'hF1;
    tbl[7].bird  = 8'hF1;  tbl[11].bird = 8'hE3;  tbl[15].bird = 8'h8F;
    tbl[19].bird = 8'hF8;  tbl[23].bird = 8'hF1;
    tbl[9].passed  = 1'b1; tbl[13].passed = 1'b1; tbl[17].passed = 1'b1;
    tbl[21].passed = 1'b1; tbl[25].passed = 1'b1;

    // Reset held for 3 cycles.
    bus.freeze = 1'b0;
    reset      = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_red", 64'(bus.red), 64'h0);
    check("rst_bird", 64'(bus.bird_col_red), 64'h0);
    check("rst_tick", 64'(bus.scroll_tick), 64'h0);
    check("rst_passed", 64'(bus.pipe_passed), 64'h0);
    reset = 1'b0;

    // Tabled pipe sequence, then a longer run checking pass cadence and period.
    exp_passes = 0;
    for (int k = 1; k <= 60; k++) begin
      wait_tick(n);
`ifdef PIPE_SPEEDUP_EN
      exp_period = (exp_passes >= 4) ? 2 : 4;
`else
      exp_period = 4;
`endif
      check($sformatf("period_t%0d", k), 64'(n), 64'(exp_period));
      if (k <= 25) begin
        check($sformatf("col7_t%0d", k), 64'(bus.red[7]), 64'(tbl[k].col7));
        check($sformatf("bird_t%0d", k), 64'(bus.bird_col_red), 64'(tbl[k].bird));
        check($sformatf("passed_t%0d", k), 64'(bus.pipe_passed), 64'(tbl[k].passed));
      end else begin
        check($sformatf("passed_t%0d", k), 64'(bus.pipe_passed), 64'((k % 4) == 1));
      end
      if ((k >= 9) && ((k % 4) == 1)) exp_passes++;
    end
    check("stray_passed", 64'(stray), 64'h0);

    // Freeze one cycle into a period for 20 cycles.
    @(negedge clock);
    snap       = bus.red;
    bus.freeze = 1'b1;
    frozen_bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.scroll_tick || bus.pipe_passed) frozen_bad++;
    end
    check("frz_pulses", 64'(frozen_bad), 64'h0);
    check("frz_red", 64'(bus.red), 64'(snap));
    bus.freeze = 1'b0;
    wait_tick(n);
`ifdef PIPE_SPEEDUP_EN
    check("frz_resume", 64'(n), 64'd1);
`else
    check("frz_resume", 64'(n), 64'd3);
`endif

    // Reset asserted on the cycle a tick would fire.
`ifdef PIPE_SPEEDUP_EN
    lead = 1;
`else
    lead = 3;
`endif
    repeat (lead) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rtk_red", 64'(bus.red), 64'h0);
    check("rtk_tick", 64'(bus.scroll_tick), 64'h0);
    check("rtk_passed", 64'(bus.pipe_passed), 64'h0);
    reset = 1'b0;

    // Fresh start: first pipe proves the LFSR reloaded its seed.
    for (int k = 1; k <= 5; k++) begin
      wait_tick(n);
      check($sformatf("rst2_period_t%0d", k), 64'(n), 64'd4);
      check($sformatf("rst2_col7_t%0d", k), 64'(bus.red[7]), 64'(tbl[k].col7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
